// File: rtl/sync_event_det.sv
// Multi-channel async event receiver: per-channel synchronizer, stability filter,
// mode-qualified edge detector, sticky pending/overflow flags and a combined irq.
module sync_event_det #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       async_in,
  input  logic [2*CH-1:0]     mode,
  input  logic [FILT_W-1:0]   filt_len,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       level_out,
  output logic [CH-1:0]       pulse_out,
  output logic [CH-1:0]       pend_out,
  output logic [CH-1:0]       ovf_out,
  output logic                irq
);

  logic [CH-1:0]     sync_q [SYNC_STAGES];
  logic [CH-1:0]     sync_d [SYNC_STAGES];
  logic [FILT_W-1:0] cnt_q  [CH];
  logic [FILT_W-1:0] cnt_d  [CH];
  logic [CH-1:0]     lvl_q, lvl_d;
  logic [CH-1:0]     pulse_q, pulse_d;
  logic [CH-1:0]     pend_q, pend_d;
  logic [CH-1:0]     ovf_q, ovf_d;
  logic [CH-1:0]     s;
  logic [CH-1:0]     accept;
  logic [CH-1:0]     qual;

  // First stage samples the raw input directly; nothing combinational ahead of it.
  always_comb begin
    sync_d[0] = async_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    lvl_d   = lvl_q;
    pulse_d = '0;
    pend_d  = pend_q & ~clr;
    ovf_d   = ovf_q & ~clr;
    accept  = '0;
    qual    = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= filt_len) begin
        accept[i] = 1'b1;
        lvl_d[i]  = s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + FILT_W'(1);
      end
      // mode bit 0 enables rising edges, bit 1 enables falling edges
      qual[i] = accept[i] & ((s[i] & mode[2*i]) | (~s[i] & mode[2*i+1]));
      if (qual[i]) begin
        pulse_d[i] = 1'b1;
        pend_d[i]  = 1'b1;
        if (pend_q[i]) begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
      lvl_q   <= '0;
      pulse_q <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign level_out = lvl_q;
  assign pulse_out = pulse_q;
  assign pend_out  = pend_q;
  assign ovf_out   = ovf_q;
  assign irq       = |pend_q;

endmodule
